// File: rtl/mdu_sched_pkg.sv
// Shared MDU operation codes and decode helpers for the multiply/divide scheduler.
package mdu_sched_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5
  } mdu_op_e;

  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sched_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_wdata;
      if (lo_we) lo <= lo_wdata;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// Issues MDU-class instructions to the external mdu_core, stalls EX until the
// result returns (or the watchdog gives up), and owns HI/LO.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WATCHDOG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              ex_stall,
  output logic              stallreq_for_ex,
  output logic              mdu_start,
  output logic              mdu_is_div,
  output logic              mdu_signed,
  output logic [DATA_W-1:0] mdu_a,
  output logic [DATA_W-1:0] mdu_b,
  output logic              mdu_cancel,
  input  logic              mdu_done,
  input  logic [DATA_W-1:0] mdu_hi,
  input  logic [DATA_W-1:0] mdu_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_e;

  localparam int CNT_W = $clog2(WATCHDOG);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG - 1);

  state_e            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;

  logic              op_arith;
  logic              div_by_zero;
  logic              in_idle;
  logic              in_busy;
  logic              wd_expire;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;

  // Start/stall/cancel are combinational so the core starts in the EX cycle itself.
  always_comb begin
    op_arith    = req_valid && op_is_arith(req_op);
    div_by_zero = op_arith && op_is_div(req_op) && (src_b == '0);
    in_idle     = rst && (state_reg == ST_IDLE);
    in_busy     = rst && (state_reg == ST_BUSY);
    wd_expire   = in_busy && !mdu_done && (cnt_reg == WD_LAST);

    mdu_start       = in_idle && op_arith && !div_by_zero;
    mdu_cancel      = wd_expire;
    stallreq_for_ex = mdu_start || (in_busy && !mdu_done && !wd_expire);
  end

  assign mdu_is_div = op_is_div(req_op);
  assign mdu_signed = op_is_signed(req_op);
  assign mdu_a      = src_a;
  assign mdu_b      = src_b;

  // Divide-by-zero is resolved locally: HI takes the dividend, LO all ones.
  always_comb begin
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
    if (in_busy && mdu_done) begin
      hi_we    = 1'b1;
      lo_we    = 1'b1;
      hi_wdata = mdu_hi;
      lo_wdata = mdu_lo;
    end else if (div_by_zero && in_idle) begin
      hi_we    = 1'b1;
      lo_we    = 1'b1;
      hi_wdata = src_a;
      lo_wdata = '1;
    end else if (in_idle && req_valid && (req_op == MDU_OP_MTHI)) begin
      hi_we    = 1'b1;
      hi_wdata = src_a;
    end else if (in_idle && req_valid && (req_op == MDU_OP_MTLO)) begin
      lo_we    = 1'b1;
      lo_wdata = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mdu_start) begin
            state_reg <= ST_BUSY;
            cnt_reg   <= '0;
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            state_reg <= ex_stall ? ST_HOLD : ST_IDLE;
          end else if (wd_expire) begin
            err_reg   <= 1'b1;
            state_reg <= ex_stall ? ST_HOLD : ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          // The finished instruction is still in EX; never reissue it.
          if (!ex_stall) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign err = err_reg;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with a cycle-timeline model of the core and HI/LO.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int WD = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        ex_stall;
  logic        stallreq_for_ex, mdu_start, mdu_is_div, mdu_signed, mdu_cancel;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_done;
  logic [31:0] mdu_hi, mdu_lo;
  logic [31:0] hi, lo;
  logic        err;

  int checks = 0;
  int errors = 0;
  int starts_seen = 0;

  // Model expectations: combinational ones for the current cycle, registered ones after the last edge.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_start, exp_cancel, exp_is_div, exp_signed;
  logic [31:0] exp_a, exp_b;
  logic [31:0] exp_hi, exp_lo, pend_hi, pend_lo;
  logic        exp_err, pend_err;

  mdu_sched #(.DATA_W(32), .WATCHDOG(WD)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .src_a           (src_a),
    .src_b           (src_b),
    .ex_stall        (ex_stall),
    .stallreq_for_ex (stallreq_for_ex),
    .mdu_start       (mdu_start),
    .mdu_is_div      (mdu_is_div),
    .mdu_signed      (mdu_signed),
    .mdu_a           (mdu_a),
    .mdu_b           (mdu_b),
    .mdu_cancel      (mdu_cancel),
    .mdu_done        (mdu_done),
    .mdu_hi          (mdu_hi),
    .mdu_lo          (mdu_lo),
    .hi              (hi),
    .lo              (lo),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) if (rst === 1'b1 && mdu_start === 1'b1) starts_seen++;

  always @(negedge clk) begin
    if (chk_en) begin
      check1("stallreq", stallreq_for_ex, exp_stall);
      check1("start", mdu_start, exp_start);
      check1("cancel", mdu_cancel, exp_cancel);
      check32("hi", hi, exp_hi);
      check32("lo", lo, exp_lo);
      check1("err", err, exp_err);
      if (exp_start) begin
        check1("is_div", mdu_is_div, exp_is_div);
        check1("signed", mdu_signed, exp_signed);
        check32("mdu_a", mdu_a, exp_a);
        check32("mdu_b", mdu_b, exp_b);
      end
    end
  end

  // What an ideal core returns: {hi, lo} = product, or {remainder, quotient}.
  function automatic logic [63:0] core_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (op)
      MDU_OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      MDU_OP_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_OP_DIV: begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      MDU_OP_DIVU: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_hi  = pend_hi;
    exp_lo  = pend_lo;
    exp_err = pend_err;
  endtask

  task automatic quiet();
    req_valid  = 1'b0;
    req_op     = MDU_OP_MULT;
    src_a      = 32'd0;
    src_b      = 32'd0;
    mdu_done   = 1'b0;
    mdu_hi     = 32'd0;
    mdu_lo     = 32'd0;
    ex_stall   = 1'b0;
    exp_stall  = 1'b0;
    exp_start  = 1'b0;
    exp_cancel = 1'b0;
  endtask

  // Single-cycle local op (MTHI/MTLO/divide-by-zero), held in EX for n cycles.
  task automatic local_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    for (int c = 0; c < n; c++) begin
      quiet();
      req_valid = 1'b1;
      req_op    = op;
      src_a     = a;
      src_b     = b;
      ex_stall  = (c < n - 1);
      if (op == MDU_OP_MTHI) pend_hi = a;
      else if (op == MDU_OP_MTLO) pend_lo = a;
      else begin
        pend_hi = a;
        pend_lo = 32'hFFFF_FFFF;
      end
      tick();
    end
    quiet();
    $display("txn local op=%0d a=%h b=%h held=%0d", op, a, b, n);
  endtask

  // Core op taking 'latency' cycles after start; ex_stall stays high 'hold' cycles from the finishing cycle.
  task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int latency, input int hold);
    logic [63:0] res;
    res = core_model(op, a, b);
    quiet();
    req_valid  = 1'b1;
    req_op     = op;
    src_a      = a;
    src_b      = b;
    exp_start  = 1'b1;
    exp_stall  = 1'b1;
    exp_is_div = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    exp_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    exp_a      = a;
    exp_b      = b;
    tick();
    for (int k = 1; k <= WD; k++) begin
      quiet();
      req_valid = 1'b1;
      req_op    = op;
      src_a     = a;
      src_b     = b;
      if (k == latency) begin
        mdu_done = 1'b1;
        mdu_hi   = res[63:32];
        mdu_lo   = res[31:0];
        pend_hi  = res[63:32];
        pend_lo  = res[31:0];
        ex_stall = (hold > 0);
        tick();
        break;
      end else if (k == WD) begin
        exp_cancel = 1'b1;
        pend_err   = 1'b1;
        ex_stall   = (hold > 0);
        tick();
        break;
      end else begin
        if (k >= 2) begin
          req_op = MDU_OP_MTHI;
          src_a  = 32'hDEAD_BEEF;
        end
        exp_stall = 1'b1;
        tick();
      end
    end
    for (int h = 1; h <= hold; h++) begin
      quiet();
      req_valid = 1'b1;
      req_op    = op;
      src_a     = a;
      src_b     = b;
      ex_stall  = (h < hold);
      if (h == 1) begin
        mdu_done = 1'b1;
        mdu_hi   = 32'h5555_5555;
        mdu_lo   = 32'hAAAA_AAAA;
      end
      tick();
    end
    quiet();
    $display("txn core op=%0d a=%h b=%h latency=%0d hold=%0d -> hi=%h lo=%h err=%b", op, a, b, latency, hold, hi, lo, err);
  endtask

  initial begin
    rst      = 1'b0;
    quiet();
    pend_hi  = 32'd0;
    pend_lo  = 32'd0;
    pend_err = 1'b0;
    exp_is_div = 1'b0;
    exp_signed = 1'b0;
    exp_a = 32'd0;
    exp_b = 32'd0;
    tick();
    chk_en = 1'b1;
    // A request during reset must not start or stall.
    req_valid = 1'b1;
    req_op    = MDU_OP_MULT;
    src_a     = 32'd3;
    src_b     = 32'd4;
    tick();
    quiet();
    rst = 1'b1;
    tick();
    $display("txn reset hi=%h lo=%h err=%b", hi, lo, err);
    check32("reset_hi_lit", hi, 32'd0);

    local_op(MDU_OP_MTHI, 32'h1234_5678, 32'h0, 2);
    local_op(MDU_OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1);
    check32("t3_hi_lit", hi, 32'h1234_5678);
    check32("t3_lo_lit", lo, 32'h9ABC_DEF0);

    local_op(MDU_OP_DIVU, 32'd100, 32'd0, 1);
    check32("t2_hi_lit", hi, 32'd100);
    check32("t2_lo_lit", lo, 32'hFFFF_FFFF);
    local_op(MDU_OP_DIV, 32'h8000_0000, 32'd0, 1);
    check32("divz_hi_lit", hi, 32'h8000_0000);

    run_arith(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5, 32, 0);
    check32("t1_hi_lit", hi, 32'hFFFF_FFFF);
    check32("t1_lo_lit", lo, 32'hFFFF_FFF1);

    run_arith(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 3);
    check32("t4_hi_lit", hi, 32'hFFFF_FFFF);
    check32("t4_lo_lit", lo, 32'hFFFF_FFFD);

    // Done arriving on the watchdog's last cycle wins over the cancel.
    run_arith(MDU_OP_DIVU, 32'd1000, 32'd7, WD, 0);
    check32("wdtie_hi_lit", hi, 32'd6);
    check32("wdtie_lo_lit", lo, 32'd142);
    check1("wdtie_err_lit", err, 1'b0);

    run_arith(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1000, 2);
    check1("t5_err_lit", err, 1'b1);
    check32("t5_hi_lit", hi, 32'd6);

    // Reset ten cycles into BUSY, then a stale done.
    quiet();
    req_valid  = 1'b1;
    req_op     = MDU_OP_MULT;
    src_a      = 32'd9;
    src_b      = 32'd9;
    exp_start  = 1'b1;
    exp_stall  = 1'b1;
    exp_is_div = 1'b0;
    exp_signed = 1'b1;
    exp_a      = 32'd9;
    exp_b      = 32'd9;
    tick();
    for (int k = 1; k <= 10; k++) begin
      quiet();
      req_valid = 1'b1;
      req_op    = MDU_OP_MULT;
      src_a     = 32'd9;
      src_b     = 32'd9;
      if (k == 10) begin
        rst      = 1'b0;
        pend_hi  = 32'd0;
        pend_lo  = 32'd0;
        pend_err = 1'b0;
      end else begin
        exp_stall = 1'b1;
      end
      tick();
    end
    quiet();
    rst      = 1'b1;
    mdu_done = 1'b1;
    mdu_hi   = 32'h0BAD_0BAD;
    mdu_lo   = 32'h0BAD_0BAD;
    tick();
    quiet();
    tick();
    tick();
    $display("txn reset-in-busy hi=%h lo=%h err=%b", hi, lo, err);
    check32("t6_hi_lit", hi, 32'd0);
    check32("t6_lo_lit", lo, 32'd0);
    check1("t6_err_lit", err, 1'b0);
    check32("start_count", 32'(starts_seen), 32'd5);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
